// File: rtl/balls_pkg.sv
// Shared constants and types for the ball collision detector and speed calculator.
package balls_pkg;

    localparam int BALL_COUNT  = 3;
    localparam int ID_W        = 4;
    localparam int COORD_W     = 11;
    localparam int HIT_DIST_SQ = 1024;
    localparam int HOLD_CYCLES = 4;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ID_W-1:0]    ball_id_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } det_state_t;

endpackage

// File: rtl/ball_pair_geometry.sv
// Combinational contact test for one ball pair: squared distance, approach dot product, hit.
module ball_pair_geometry #(
    parameter int COORD_W     = 11,
    parameter int HIT_DIST_SQ = 1024,
    localparam int PW         = 2 * (COORD_W + 1) + 1
) (
    input  logic [COORD_W-1:0]   xi,
    input  logic [COORD_W-1:0]   yi,
    input  logic [COORD_W-1:0]   xj,
    input  logic [COORD_W-1:0]   yj,
    input  logic [COORD_W-1:0]   vxi,
    input  logic [COORD_W-1:0]   vyi,
    input  logic [COORD_W-1:0]   vxj,
    input  logic [COORD_W-1:0]   vyj,
    output logic [PW-1:0]        d2,
    output logic signed [PW-1:0] dot,
    output logic                 hit
);

    localparam logic [PW-1:0] HIT_THRESH = PW'(HIT_DIST_SQ);

    logic signed [COORD_W:0] dx_n, dy_n, dvx_n, dvy_n;
    logic signed [PW-1:0]    dx, dy, dvx, dvy;

    // Positions are unsigned, so zero-extend before subtracting; speeds are signed.
    assign dx_n  = $signed({1'b0, xj}) - $signed({1'b0, xi});
    assign dy_n  = $signed({1'b0, yj}) - $signed({1'b0, yi});
    assign dvx_n = $signed({vxj[COORD_W-1], vxj}) - $signed({vxi[COORD_W-1], vxi});
    assign dvy_n = $signed({vyj[COORD_W-1], vyj}) - $signed({vyi[COORD_W-1], vyi});

    assign dx  = {{(PW-COORD_W-1){dx_n[COORD_W]}},  dx_n};
    assign dy  = {{(PW-COORD_W-1){dy_n[COORD_W]}},  dy_n};
    assign dvx = {{(PW-COORD_W-1){dvx_n[COORD_W]}}, dvx_n};
    assign dvy = {{(PW-COORD_W-1){dvy_n[COORD_W]}}, dvy_n};

    assign d2  = dx * dx + dy * dy;
    assign dot = dvx * dx + dvy * dy;
    assign hit = (d2 < HIT_THRESH) && dot[PW-1];

endmodule

// File: rtl/balls_pair_collision_detector.sv
// Per-frame pair scanner: reports the first approaching, touching ball pair for a fixed hold time.
module balls_pair_collision_detector
    import balls_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                startOfFrame,
    input  logic [BALL_COUNT-1:0][COORD_W-1:0]  topLeftX_VEC_in,
    input  logic [BALL_COUNT-1:0][COORD_W-1:0]  topLeftY_VEC_in,
    input  logic [BALL_COUNT-1:0][COORD_W-1:0]  Xspeed_VEC_in,
    input  logic [BALL_COUNT-1:0][COORD_W-1:0]  Yspeed_VEC_in,
    output logic [BALL_COUNT-1:0]               balls_collide,
    output logic [1:0][ID_W-1:0]                Balls_col_ID,
    output logic                                collision_valid,
    output logic                                scan_done
);

    localparam int PW     = 2 * (COORD_W + 1) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int IDX_W  = (BALL_COUNT > 1) ? $clog2(BALL_COUNT) : 1;
    localparam ball_id_t LAST_I = ball_id_t'(BALL_COUNT - 2);
    localparam ball_id_t LAST_J = ball_id_t'(BALL_COUNT - 1);

    det_state_t        state_reg, state_next;
    ball_id_t          i_reg, i_next, j_reg, j_next;
    ball_id_t          lo_reg, lo_next, hi_reg, hi_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              done_reg, done_next;
    logic              in_report;

    coord_t            xi, yi, xj, yj, vxi, vyi, vxj, vyj;
    logic [PW-1:0]     pair_d2;
    logic signed [PW-1:0] pair_dot;
    logic              pair_hit;
    logic              unused_geom;

    // i and j never exceed BALL_COUNT-1, so the low index bits address every ball.
    assign xi  = topLeftX_VEC_in[i_reg[IDX_W-1:0]];
    assign yi  = topLeftY_VEC_in[i_reg[IDX_W-1:0]];
    assign vxi = Xspeed_VEC_in[i_reg[IDX_W-1:0]];
    assign vyi = Yspeed_VEC_in[i_reg[IDX_W-1:0]];
    assign xj  = topLeftX_VEC_in[j_reg[IDX_W-1:0]];
    assign yj  = topLeftY_VEC_in[j_reg[IDX_W-1:0]];
    assign vxj = Xspeed_VEC_in[j_reg[IDX_W-1:0]];
    assign vyj = Yspeed_VEC_in[j_reg[IDX_W-1:0]];

    ball_pair_geometry #(
        .COORD_W     (COORD_W),
        .HIT_DIST_SQ (HIT_DIST_SQ)
    ) u_geometry (
        .xi  (xi),
        .yi  (yi),
        .xj  (xj),
        .yj  (yj),
        .vxi (vxi),
        .vyi (vyi),
        .vxj (vxj),
        .vyj (vyj),
        .d2  (pair_d2),
        .dot (pair_dot),
        .hit (pair_hit)
    );

    assign unused_geom = ^{pair_d2, pair_dot};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= ball_id_t'(1);
            lo_reg    <= '0;
            hi_reg    <= '0;
            hold_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            hold_reg  <= hold_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        hold_next  = hold_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (startOfFrame) begin
                    if (BALL_COUNT < 2) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = SCAN;
                        i_next     = '0;
                        j_next     = ball_id_t'(1);
                    end
                end
            end
            SCAN: begin
                if (pair_hit) begin
                    state_next = REPORT;
                    lo_next    = i_reg;
                    hi_next    = j_reg;
                    hold_next  = HOLD_W'(HOLD_CYCLES);
                end else if (i_reg == LAST_I && j_reg == LAST_J) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (j_reg == LAST_J) begin
                    i_next = i_reg + ball_id_t'(1);
                    j_next = i_reg + ball_id_t'(2);
                end else begin
                    j_next = j_reg + ball_id_t'(1);
                end
            end
            REPORT: begin
                hold_next = hold_reg - HOLD_W'(1);
                if (hold_reg == HOLD_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_report       = (state_reg == REPORT);
        collision_valid = in_report;
        scan_done       = done_reg;
        Balls_col_ID    = '0;
        if (in_report) begin
            Balls_col_ID[0] = lo_reg;
            Balls_col_ID[1] = hi_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < BALL_COUNT; gi++) begin : g_flags
            assign balls_collide[gi] = in_report &&
                ((lo_reg == ball_id_t'(gi)) || (hi_reg == ball_id_t'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_balls_pair_collision_detector.sv
// Randomized scoreboard bench for the ball pair collision detector.
module tb_balls_pair_collision_detector;

    localparam int N      = 3;
    localparam int CW     = 11;
    localparam int IW     = 4;
    localparam int HOLD   = 4;
    localparam int NPAIRS = N * (N - 1) / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startOfFrame = 1'b0;
    logic [N-1:0][CW-1:0] x_vec, y_vec, vx_vec, vy_vec;
    logic [N-1:0]         balls_collide;
    logic [1:0][IW-1:0]   Balls_col_ID;
    logic                 collision_valid;
    logic                 scan_done;

    int xs[N], ys[N], vxs[N], vys[N];

    typedef struct {
        bit hit;
        int lo;
        int hi;
        int cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;
    int edge_cnt = 0;
    int exp_len = HOLD;
    int run_len = 0;
    bit prev_valid = 1'b0;

    balls_pair_collision_detector dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .topLeftX_VEC_in (x_vec),
        .topLeftY_VEC_in (y_vec),
        .Xspeed_VEC_in   (vx_vec),
        .Yspeed_VEC_in   (vy_vec),
        .balls_collide   (balls_collide),
        .Balls_col_ID    (Balls_col_ID),
        .collision_valid (collision_valid),
        .scan_done       (scan_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference: walk pairs in scan order with plain integer geometry.
    function automatic exp_t model_frame(input int start_edge);
        exp_t e;
        int k, dx, dy, d2, dot;
        e.hit = 1'b0; e.lo = 0; e.hi = 0; e.cyc = start_edge + NPAIRS;
        k = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (!e.hit) begin
                    dx  = xs[j] - xs[i];
                    dy  = ys[j] - ys[i];
                    d2  = dx * dx + dy * dy;
                    dot = (vxs[j] - vxs[i]) * dx + (vys[j] - vys[i]) * dy;
                    if (d2 < 1024 && dot < 0) begin
                        e.hit = 1'b1; e.lo = i; e.hi = j; e.cyc = start_edge + k + 1;
                    end
                end
                k++;
            end
        end
        return e;
    endfunction

    task automatic apply();
        x_vec  = {CW'(xs[2]),  CW'(xs[1]),  CW'(xs[0])};
        y_vec  = {CW'(ys[2]),  CW'(ys[1]),  CW'(ys[0])};
        vx_vec = {CW'(vxs[2]), CW'(vxs[1]), CW'(vxs[0])};
        vy_vec = {CW'(vys[2]), CW'(vys[1]), CW'(vys[0])};
    endtask

    task automatic setup(input int x0, x1, x2, y0, y1, y2,
                         input int vx0, vx1, vx2, vy0, vy1, vy2);
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        ys[0] = y0; ys[1] = y1; ys[2] = y2;
        vxs[0] = vx0; vxs[1] = vx1; vxs[2] = vx2;
        vys[0] = vy0; vys[1] = vy1; vys[2] = vy2;
        apply();
    endtask

    task automatic start_frame(input bit expect_it);
        @(negedge clk);
        startOfFrame = 1'b1;
        if (expect_it) q.push_back(model_frame(edge_cnt + 1));
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!collision_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("report_within_budget", int'(n < 20), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || collision_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_within_budget", int'(n < 40), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame();
        start_frame(1'b1);
        wait_done();
    endtask

    // Monitor: pops one expectation per report or scan_done and checks it.
    always @(negedge clk) begin
        exp_t e;
        if (collision_valid && !prev_valid) begin
            if (q.size() == 0) begin
                check("unexpected_report", 1, 0);
            end else begin
                e = q.pop_front();
                check("report_expected", 1, int'(e.hit));
                if (e.hit) begin
                    check("id_lo", int'(Balls_col_ID[0]), e.lo);
                    check("id_hi", int'(Balls_col_ID[1]), e.hi);
                    check("collide_mask", int'(balls_collide), (1 << e.lo) | (1 << e.hi));
                    check("report_cycle", edge_cnt, e.cyc);
                end
            end
        end
        if (scan_done) begin
            if (q.size() == 0) begin
                check("unexpected_scan_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("scan_done_expected", 0, int'(e.hit));
                check("scan_done_cycle", edge_cnt, e.cyc);
            end
        end
        if (collision_valid) begin
            run_len++;
        end else begin
            if (prev_valid) check("hold_length", run_len, exp_len);
            run_len = 0;
            check("idle_outputs", int'({balls_collide, Balls_col_ID}), 0);
        end
        prev_valid = collision_valid;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        setup(100, 130, 400, 200, 200, 200, 2, -2, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_valid", int'(collision_valid), 0);
        check("reset_scan_done", int'(scan_done), 0);
        reset = 1'b0;

        // Touching and approaching
        setup(100, 130, 400, 200, 200, 200, 2, -2, 0, 0, 0, 0);
        run_frame();
        // Overlapping but separating
        setup(100, 130, 400, 200, 200, 200, -2, 2, 0, 0, 0, 0);
        run_frame();
        // Later pair only
        setup(1000, 300, 320, 900, 50, 50, 0, 0, -1, 0, 0, 0);
        run_frame();
        // Two hits: only the first is reported, restart during REPORT ignored
        setup(100, 130, 160, 200, 200, 200, 2, 0, -2, 0, 0, 0);
        start_frame(1'b1);
        wait_valid();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        // Distance exactly at threshold, then just inside it
        setup(100, 132, 600, 200, 200, 200, 2, -2, 0, 0, 0, 0);
        run_frame();
        setup(100, 131, 600, 200, 200, 200, 2, -2, 0, 0, 0, 0);
        run_frame();
        // Negative dx with approaching sign, near the top of the coordinate range
        setup(130, 100, 600, 200, 200, 200, -2, 2, 0, 0, 0, 0);
        run_frame();
        setup(2000, 1990, 10, 2040, 2040, 10, -3, 3, 0, 0, 0, 0);
        run_frame();
        // Vertical-only approach
        setup(500, 900, 505, 100, 300, 120, 0, 0, 0, 1, 0, -1);
        run_frame();

        // Reset during REPORT cycle 2, then restart
        exp_len = 2;
        setup(100, 130, 400, 200, 200, 200, 2, -2, 0, 0, 0, 0);
        start_frame(1'b1);
        wait_valid();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_clears_valid", int'(collision_valid), 0);
        reset = 1'b0;
        @(negedge clk);
        exp_len = HOLD;
        run_frame();

        // startOfFrame together with reset: reset wins, nothing reported
        @(negedge clk);
        reset = 1'b1;
        startOfFrame = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        startOfFrame = 1'b0;
        repeat (8) @(negedge clk);

        // Randomized frames
        for (int r = 0; r < 60; r++) begin
            for (int k = 0; k < N; k++) begin
                if (r % 2 == 0) begin
                    xs[k] = int'($urandom_range(100, 170));
                    ys[k] = int'($urandom_range(100, 170));
                    vxs[k] = int'($urandom_range(0, 8)) - 4;
                    vys[k] = int'($urandom_range(0, 8)) - 4;
                end else begin
                    xs[k] = int'($urandom_range(0, 2047));
                    ys[k] = int'($urandom_range(0, 2047));
                    vxs[k] = int'($urandom_range(0, 2047)) - 1024;
                    vys[k] = int'($urandom_range(0, 2047)) - 1024;
                end
            end
            apply();
            run_frame();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/balls_pair_collision_detector.md
Name: balls_pair_collision_detector

Overview:
- Per-frame scanner that finds the first colliding ball pair and drives the collision flags and ID pair consumed by the ball speed calculator.
- Sits directly upstream of the speed calculator and reads the same position and speed vectors.
- Walks all unordered pairs (i<j), one pair per clock, after each startOfFrame.
- A pair hits when the squared centre distance is below the threshold and the balls are approaching.
- Reports one pair per frame for HOLD_CYCLES cycles.

Parameters:
- BALL_COUNT, 3: number of balls; ball IDs are 0..BALL_COUNT-1.
- ID_W, 4: width of one ball ID.
- COORD_W, 11: width of a position or speed word. Speeds are two's complement; positions are unsigned.
- HIT_DIST_SQ, 1024: squared centre distance for contact (32 px diameter squared).
- HOLD_CYCLES, 4: number of cycles a found pair is presented on the outputs.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse; starts a scan
- topLeftX_VEC_in  in  BALL_COUNT x COORD_W  top-left X of each ball
- topLeftY_VEC_in  in  BALL_COUNT x COORD_W  top-left Y of each ball
- Xspeed_VEC_in  in  BALL_COUNT x COORD_W  signed X speed of each ball
- Yspeed_VEC_in  in  BALL_COUNT x COORD_W  signed Y speed of each ball
- balls_collide  out  BALL_COUNT  one-hot-pair flags; bits lo and hi set while reporting
- Balls_col_ID  out  2 x ID_W  [0] holds the lower ID, [1] the higher ID
- collision_valid  out  1  high while a pair is presented
- scan_done  out  1  one-cycle pulse when a scan ends without a hit

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; i=0, j=1; hold counter = 0.
  - balls_collide = 0, Balls_col_ID = {0,0}, collision_valid = 0, scan_done = 0.
  - Reset asserted in any state aborts the operation at the next edge.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - startOfFrame=1 -> SCAN with i=0, j=1.
  - Otherwise stay in IDLE with outputs 0.
- SCAN: each cycle evaluates pair (i,j) combinationally.
  - dx = X[j]-X[i] and dy = Y[j]-Y[i], sign-extended to COORD_W+1 bits. Both balls are the same size, so top-left difference equals centre difference.
  - d2 = dx*dx + dy*dy, unsigned, 2*(COORD_W+1)+1 bits. No truncation.
  - dot = (vxj-vxi)*dx + (vyj-vyi)*dy, signed, 2*(COORD_W+1)+1 bits.
  - hit = (d2 < HIT_DIST_SQ) && (dot < 0). A pair with dot >= 0 is separating and is never reported; this prevents re-triggering while the balls overlap.
  - On hit: register lo=i, hi=j, load the hold counter with HOLD_CYCLES, go to REPORT. The outputs are valid on the cycle after the hit cycle.
  - On no hit, advance: j+1; if j == BALL_COUNT-1 then i+1 and j = i+2.
  - If (i,j) is the last pair (BALL_COUNT-2, BALL_COUNT-1) and there is no hit: pulse scan_done for one cycle, go to IDLE.
  - A full scan takes BALL_COUNT*(BALL_COUNT-1)/2 cycles; 3 cycles at the defaults.
  - Lower-indexed pairs win: only the first hit in scan order is reported per frame.
- REPORT:
  - collision_valid = 1; balls_collide[lo] = balls_collide[hi] = 1, all other bits 0.
  - Balls_col_ID = {hi, lo}, i.e. Balls_col_ID[1] = hi, Balls_col_ID[0] = lo.
  - The counter decrements every cycle. When it reaches 1 and decrements, go to IDLE, clearing all outputs on that edge. Outputs are therefore high for exactly HOLD_CYCLES cycles.
- startOfFrame while in SCAN or REPORT is ignored (no restart, no queuing).
- startOfFrame in the same cycle as reset: reset wins.
- Inputs are sampled live each SCAN cycle; upstream holds positions and speeds stable between frames.
- BALL_COUNT < 2: stay in IDLE, pulse scan_done on startOfFrame.

Decomposition:
- Package balls_pkg:
  - constants BALL_COUNT, COORD_W, ID_W, HIT_DIST_SQ;
  - typedefs coord_t (logic [COORD_W-1:0]) and ball_id_t;
  - enum det_state_t {IDLE, SCAN, REPORT}.
  - The speed calculator shares the same package.
- One combinational sub-module, ball_pair_geometry:
  - inputs: two positions and two speeds;
  - outputs: d2, dot, hit.
  - The FSM, pair indices and hold counter stay in the top.

Test Plan:
- Touching and approaching: X = {100,130,400}, Y all 200; speeds ball0 vx=+2, ball1 vx=-2, others 0. Pulse startOfFrame -> hit on first SCAN cycle (d2=900<1024, dot=-120). Next cycle Balls_col_ID={1,0}, balls_collide=3'b011, collision_valid high for exactly 4 cycles, then all outputs 0.
- Overlapping but separating: same positions, ball0 vx=-2, ball1 vx=+2 -> no report; scan_done pulses 3 cycles after the first SCAN cycle.
- Later pair only: ball0 far away; balls 1 and 2 at X=300/320, Y=50/50, vx2=-1 -> Balls_col_ID={2,1}, balls_collide=3'b110.
- Two hits in one frame: pairs (0,1) and (1,2) both hitting -> only {1,0} is reported; no second report until the next startOfFrame.
- Reset during REPORT cycle 2: all outputs 0 on the next edge, state IDLE. A startOfFrame one cycle after reset restarts scanning normally.
- Boundary and sign: d2 exactly 1024 (dx=32, dy=0) -> no hit. Negative dx (X[j]<X[i]) with the correct approaching sign -> hit; confirms signed extension.
